// File: rtl/pe_seq.sv
// Sequencer for a single processing element: loads TAPS weights, issues one
// sample at a time, pulses a PE clear, waits LAT cycles and hands back both sums.
module pe_seq #(
    parameter int N         = 32,
    parameter int TAPS      = 7,
    parameter int SUM_WIDTH = 2*N+4,
    parameter int LAT       = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [N-1:0]                w_data,
    input  logic                        reload,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [N-1:0]                x_data,
    output logic                        pe_clr,
    output logic [N-1:0]                pe_xin,
    output logic [N*TAPS-1:0]           pe_win,
    input  logic signed [SUM_WIDTH-1:0] pe_sum,
    input  logic signed [SUM_WIDTH-1:0] pe_sum1,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic signed [SUM_WIDTH-1:0] r_sum,
    output logic signed [SUM_WIDTH-1:0] r_sum1,
    output logic [15:0]                 r_count,
    output logic                        busy
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [2:0] {
        LOADW,
        XWAIT,
        CLEAR,
        RUN,
        OUT
    } state_t;

    state_t                      state, state_nxt;
    logic [IDX_W-1:0]            widx;
    logic [7:0]                  cnt;
    logic [TAPS-1:0][N-1:0]      wreg;

    logic w_hs;
    logic x_hs;
    logic r_hs;
    logic last_w;
    logic run_done;

    // A reload in LOADW swallows any weight offered in the same cycle.
    assign w_hs     = (state == LOADW) && w_valid && !reload;
    assign x_hs     = x_valid && x_ready;
    assign r_hs     = r_valid && r_ready;
    assign last_w   = (widx == IDX_W'(TAPS-1));
    assign run_done = (state == RUN) && (cnt == 8'(LAT-1));

    assign pe_win   = wreg;

    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        x_ready   = 1'b0;
        pe_clr    = 1'b0;
        busy      = 1'b1;
        case (state)
            LOADW: begin
                w_ready = 1'b1;
                busy    = 1'b0;
                if (w_hs && last_w)
                    state_nxt = XWAIT;
            end
            XWAIT: begin
                x_ready = !reload;
                busy    = 1'b0;
                if (reload)
                    state_nxt = LOADW;
                else if (x_valid)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                pe_clr    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cnt == 8'(LAT-1))
                    state_nxt = OUT;
            end
            OUT: begin
                if (r_ready)
                    state_nxt = XWAIT;
            end
            default: begin
                state_nxt = LOADW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= LOADW;
        else
            state <= state_nxt;
    end

    // Weight load: index wraps back to 0 once the last tap is stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx <= '0;
            wreg <= '0;
        end else begin
            if (state == LOADW && reload)
                widx <= '0;
            else if (w_hs)
                widx <= last_w ? '0 : widx + 1'b1;
            if (w_hs)
                wreg[widx] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pe_xin <= '0;
        else if (x_hs)
            pe_xin <= x_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state == CLEAR)
            cnt <= '0;
        else if (state == RUN)
            cnt <= cnt + 8'd1;
    end

    // Result capture: sums are taken verbatim from the PE in the last RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_sum1  <= '0;
        end else if (run_done) begin
            r_valid <= 1'b1;
            r_sum   <= pe_sum;
            r_sum1  <= pe_sum1;
        end else if (r_hs) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_count <= '0;
        else if (r_hs)
            r_count <= r_count + 16'd1;
    end

endmodule

// File: tb/tb_pe_seq.sv
// Bench for pe_seq: a PE stub, a result scoreboard and directed plus random stimulus.
module tb_pe_seq;

    localparam int N    = 32;
    localparam int TAPS = 7;
    localparam int SW   = 2*N+4;
    localparam int LAT  = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 w_valid, w_ready, reload;
    logic [N-1:0]         w_data;
    logic                 x_valid, x_ready;
    logic [N-1:0]         x_data;
    logic                 pe_clr;
    logic [N-1:0]         pe_xin;
    logic [N*TAPS-1:0]    pe_win;
    logic signed [SW-1:0] pe_sum, pe_sum1;
    logic                 r_valid, r_ready;
    logic signed [SW-1:0] r_sum, r_sum1;
    logic [15:0]          r_count;
    logic                 busy;

    pe_seq #(.N(N), .TAPS(TAPS), .SUM_WIDTH(SW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .reload(reload),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .pe_clr(pe_clr), .pe_xin(pe_xin), .pe_win(pe_win),
        .pe_sum(pe_sum), .pe_sum1(pe_sum1),
        .r_valid(r_valid), .r_ready(r_ready), .r_sum(r_sum), .r_sum1(r_sum1),
        .r_count(r_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] s1;
        int                   hs;
    } exp_t;

    exp_t                 q[$];
    int                   checks   = 0;
    int                   failures = 0;
    int                   cyc      = 0;
    logic [N-1:0]         w_model[TAPS];
    int                   widx_m   = 0;
    logic [N-1:0]         cur_x    = '0;
    logic [15:0]          exp_count = '0;
    logic signed [SW-1:0] stub_sum  = '0;
    logic signed [SW-1:0] stub_sum1 = '0;
    logic                 hold      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    function automatic logic [N*TAPS-1:0] pack_w();
        logic [N*TAPS-1:0] p;
        for (int i = 0; i < TAPS; i++) p[i*N +: N] = w_model[i];
        return p;
    endfunction

    function automatic logic signed [SW-1:0] rnd_sum();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[SW-1:0];
    endfunction

    // PE stub: the sums are only meaningful LAT cycles after the clear cycle.
    initial begin
        int k;
        k = -1;
        forever begin
            @(negedge clk);
            if (!rst) k = -1;
            else if (pe_clr) k = 0;
            else if (k >= 0) k++;
            if (k == LAT) begin
                pe_sum  = stub_sum;
                pe_sum1 = stub_sum1;
                if (q.size() > 0) begin
                    chk("pe_xin_held", pe_xin, cur_x);
                    chk("pe_win_run", pe_win, pack_w());
                end
            end else begin
                pe_sum  = rnd_sum();
                pe_sum1 = rnd_sum();
            end
        end
    end

    initial begin
        r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            r_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: compares every presented result against the head of the scoreboard.
    initial begin
        logic prev_v, prev_hs;
        int   clr_len;
        prev_v = 1'b0; prev_hs = 1'b0; clr_len = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 1'b0; prev_hs = 1'b0; clr_len = 0;
                continue;
            end
            if (pe_clr) clr_len++;
            else if (clr_len > 0) begin
                chk("pe_clr_width", clr_len, 1);
                clr_len = 0;
            end
            if (prev_hs) chk("r_valid_drop", r_valid, 1'b0);
            else if (prev_v) chk("r_valid_hold", r_valid, 1'b1);
            if (r_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_r_valid actual=1 required=0");
                end else begin
                    if (!prev_v || prev_hs) begin
                        chk("latency", cyc - q[0].hs, LAT + 1);
                        chk("r_count_pre", r_count, exp_count);
                    end
                    chk("r_sum", r_sum, q[0].s);
                    chk("r_sum1", r_sum1, q[0].s1);
                    chk("ctrl_in_out", {x_ready, w_ready, busy}, 3'b001);
                    if (r_ready) begin
                        void'(q.pop_front());
                        exp_count = exp_count + 16'd1;
                    end
                end
            end
            prev_v  = r_valid;
            prev_hs = r_valid && r_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_w(input logic [N-1:0] d);
        int n;
        n = 0;
        w_valid = 1'b1;
        w_data  = d;
        #1;
        while (!w_ready && n < 100) begin @(posedge clk); #2; n++; end
        if (!w_ready) timeout("w_handshake");
        @(posedge clk);
        w_model[widx_m] = d;
        widx_m = (widx_m == TAPS-1) ? 0 : widx_m + 1;
        #1;
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [N-1:0] x, input logic signed [SW-1:0] s,
                          input logic signed [SW-1:0] s1);
        int n;
        exp_t e;
        n = 0;
        stub_sum  = s;
        stub_sum1 = s1;
        x_valid = 1'b1;
        x_data  = x;
        #1;
        while (!x_ready && n < 400) begin @(posedge clk); #2; n++; end
        if (!x_ready) timeout("x_handshake");
        @(posedge clk);
        #1;
        cur_x = x;
        e.s = s; e.s1 = s1; e.hs = cyc;
        q.push_back(e);
        x_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!x_ready && n < 400) begin step(); n++; end
        if (!x_ready) timeout("wait_idle");
    endtask

    task automatic reset_checks();
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_sum", r_sum, 0);
        chk("rst_r_sum1", r_sum1, 0);
        chk("rst_r_count", r_count, 0);
        chk("rst_pe_xin", pe_xin, 0);
        chk("rst_pe_clr", pe_clr, 1'b0);
        chk("rst_pe_win", pe_win, 0);
        chk("rst_ctrl", {w_ready, x_ready, busy}, 3'b100);
    endtask

    task automatic basic_run();
        int c0;
        c0 = cyc;
        put_w(N'(1));
        chk("w_first_edge", cyc - c0, 1);
        chk("pe_win_partial", pe_win, pack_w());
        for (int i = 2; i <= TAPS; i++) put_w(N'(i));
        chk("pe_win_1to7", pe_win, pack_w());
        send_x(N'(2), SW'(100), -SW'(5));
        wait_idle();
        chk("r_count_after", r_count, exp_count);
    endtask

    initial begin
        rst = 1'b0;
        w_valid = 1'b0; w_data = '0; reload = 1'b0;
        x_valid = 1'b0; x_data = '0;
        for (int i = 0; i < TAPS; i++) w_model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rst = 1'b1;
        chk("w_ready_after_rst", w_ready, 1'b1);

        basic_run();
        chk("r_count_one", r_count, 16'd1);

        // Long back-pressure; reload during OUT must be ignored.
        hold = 1'b1;
        send_x($urandom, rnd_sum(), rnd_sum());
        repeat (LAT + 1 + 10) step();
        reload = 1'b1; step(); reload = 1'b0;
        repeat (10) step();
        chk("r_valid_held", r_valid, 1'b1);
        chk("x_ready_held", x_ready, 1'b0);
        hold = 1'b0;
        wait_idle();

        // Reload together with x_valid in XWAIT.
        x_valid = 1'b1; x_data = 32'hCAFE_F00D; reload = 1'b1;
        #1;
        chk("x_ready_on_reload", x_ready, 1'b0);
        step();
        x_valid = 1'b0; reload = 1'b0;
        widx_m = 0;
        chk("loadw_after_reload", {w_ready, x_ready, busy}, 3'b100);
        chk("pe_xin_kept", pe_xin, cur_x);

        // Partial load, reload with a concurrent weight, then full load.
        for (int i = 0; i < 3; i++) put_w($urandom);
        chk("pe_win_3", pe_win, pack_w());
        reload = 1'b1; w_valid = 1'b1; w_data = 32'hDEAD_BEEF;
        step();
        reload = 1'b0; w_valid = 1'b0;
        widx_m = 0;
        chk("pe_win_reload", pe_win, pack_w());
        for (int i = 10; i <= 16; i++) put_w(N'(i));
        chk("pe_win_10to16", pe_win, pack_w());
        send_x($urandom, rnd_sum(), rnd_sum());
        wait_idle();

        // Reset in the middle of RUN.
        send_x($urandom, rnd_sum(), rnd_sum());
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        exp_count = '0;
        widx_m = 0;
        for (int i = 0; i < TAPS; i++) w_model[i] = '0;
        #1;
        reset_checks();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("w_ready_after_rst2", w_ready, 1'b1);
        basic_run();
        chk("r_count_one_again", r_count, 16'd1);

        // Randomised transactions with occasional weight reloads and stray reloads.
        for (int t = 0; t < 20; t++) begin
            if (t % 5 == 0) begin
                wait_idle();
                reload = 1'b1; step(); reload = 1'b0;
                widx_m = 0;
                for (int i = 0; i < TAPS; i++) put_w($urandom);
                chk("pe_win_rand", pe_win, pack_w());
            end
            hold = ($urandom_range(0, 3) == 0);
            send_x($urandom, rnd_sum(), rnd_sum());
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, LAT)) step();
                reload = 1'b1; step(); reload = 1'b0;
            end
            repeat ($urandom_range(0, 12)) step();
            hold = 1'b0;
            wait_idle();
        end

        // Counter wrap from 0xFFFF.
        force dut.r_count = 16'hFFFF;
        step();
        release dut.r_count;
        exp_count = 16'hFFFF;
        send_x($urandom, rnd_sum(), rnd_sum());
        wait_idle();
        chk("r_count_wrap", r_count, 16'h0000);
        chk("r_count_model", r_count, exp_count);
        chk("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_seq.md
PE_SEQ -- requirements
Module: pe_seq

Interface
REQ-001 Parameter N, default 32, data width of weights and input samples.
REQ-002 Parameter TAPS, default 7, number of weights per PE.
REQ-003 Parameter SUM_WIDTH, default 2*N+4, width of PE partial sums.
REQ-004 Parameter LAT, default 9, PE cycles from clear release to valid sum/sum1 (range 1..255).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 w_valid / w_ready / w_data  in / out / in  1 / 1 / N  weight load stream, w0 first.
REQ-008 reload  input  1  single-cycle pulse: discard weights and restart the weight load.
REQ-009 x_valid / x_ready / x_data  in / out / N  input sample stream.
REQ-010 pe_clr  output  1  active-high clear to the PE.
REQ-011 pe_xin  output  N  sample driven to the PE.
REQ-012 pe_win  output  N*TAPS  packed weights {w[TAPS-1],...,w0}, w0 in bits [N-1:0].
REQ-013 pe_sum / pe_sum1  input  SUM_WIDTH each  PE results, signed.
REQ-014 r_valid / r_ready / r_sum / r_sum1  out / in / out / out  1 / 1 / SUM_WIDTH / SUM_WIDTH  result stream.
REQ-015 r_count  output  16  number of results accepted, wraps 0xFFFF->0.
REQ-016 busy  output  1  high in every state except LOADW and XWAIT.

Function
REQ-017 FSM states are LOADW, XWAIT, CLEAR, RUN, OUT; the reset state is LOADW with weight index 0.
REQ-018 LOADW: w_ready=1; on w_valid&&w_ready, w_data is stored at the current index, which then increments; the handshake that stores index TAPS-1 moves the FSM to XWAIT.
REQ-019 w_ready SHALL be 0 in every state except LOADW.
REQ-020 pe_win SHALL change only on weight handshakes, and partially loaded weights SHALL be visible on pe_win.
REQ-021 XWAIT: x_ready = !reload (combinational); on x_valid&&x_ready, x_data is latched into pe_xin and the FSM moves to CLEAR.
REQ-022 reload in XWAIT moves the FSM to LOADW with index 0; reload in the same cycle as x_valid wins, and the sample is not accepted.
REQ-023 reload in LOADW resets the index to 0; any w_valid that same cycle is ignored.
REQ-024 reload in CLEAR, RUN or OUT SHALL be ignored.
REQ-025 CLEAR: pe_clr=1 for exactly one cycle, then the FSM moves to RUN with its cycle counter at 0.
REQ-026 RUN: pe_clr=0; the counter increments each cycle; in the cycle the counter equals LAT-1, pe_sum/pe_sum1 are registered into r_sum/r_sum1, r_valid rises, and the FSM moves to OUT.
REQ-027 The first r_valid SHALL occur LAT+1 cycles after the x handshake edge.
REQ-028 OUT: r_valid stays high, and r_sum/r_sum1 stay stable, until r_ready.
REQ-029 On r_valid&&r_ready: r_valid falls, r_count increments, and the FSM moves to XWAIT.
REQ-030 pe_xin SHALL hold its value from the x handshake until the next x handshake.
REQ-031 x_ready SHALL be 0 in CLEAR, RUN and OUT, so only one sample is in flight.
REQ-032 Sums SHALL pass through unmodified; the block does no sign extension or arithmetic on them.

Reset
REQ-033 Asserting rst at any time (including mid-RUN or in OUT) SHALL immediately force the following, and any in-flight result is discarded with no partial r_valid:
- FSM = LOADW, weight index = 0, all weight registers = 0;
- pe_xin = 0, pe_clr = 0;
- r_valid = 0, r_sum = 0, r_sum1 = 0, r_count = 0;
- w_ready = 1, x_ready = 0, busy = 0.
REQ-034 After rst deasserts, w_ready SHALL be 1 and the block SHALL accept a weight on the first rising edge.

Verification
REQ-035 Load weights 1..7, then send x=2; the PE stub drives pe_sum=100 and pe_sum1=-5. Required: pe_win = {7,6,5,4,3,2,1}; pe_clr is high for exactly one cycle; r_valid rises 10 cycles after the x handshake with r_sum=100 and r_sum1=-5; r_count=1 after r_ready.
REQ-036 Hold r_ready low for 20 cycles. Required: r_valid and r_sum stay stable, x_ready=0 throughout, and the result is accepted when r_ready rises.
REQ-037 In XWAIT, assert reload together with x_valid. Required: no x handshake occurs, the FSM is in LOADW, and w_ready=1 on the next cycle.
REQ-038 Load 3 weights, pulse reload, then load 10..16. Required: pe_win = {16,...,10}.
REQ-039 Drop rst at RUN cycle 4. Required: all outputs take their REQ-033 values, no r_valid is ever seen, and a clean run after reset passes the REQ-035 check.
REQ-040 Preload r_count with 65535 accepted results, then complete one more result. Required: r_count wraps to 0.
